// File: rtl/kcp_bus_pkg.sv
// Shared definitions for the KCP53K memory-bus arbiter: transfer sizes,
// arbiter state encoding and a width helper.
package kcp_bus_pkg;

  localparam logic [1:0] SIZ_BYTE  = 2'd0;
  localparam logic [1:0] SIZ_HALF  = 2'd1;
  localparam logic [1:0] SIZ_WORD  = 2'd2;
  localparam logic [1:0] SIZ_DWORD = 2'd3;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } arb_state_e;

  // ceil(log2(n)), never less than 1 so a 1-bit index always exists
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Bundle of the N master ports and the single X-port slave connection.
// The master modport is the arbiter's view; slave is the environment's view.
interface bus_arbiter_rr_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 64
);

  logic [NM*DW-1:0] m_dat_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_signed_i;
  logic [2*NM-1:0]  m_siz_i;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM*DW-1:0] m_dat_o;

  logic [DW-1:0]    xdat_o;
  logic [AW-1:0]    xadr_o;
  logic             xwe_o;
  logic             xcyc_o;
  logic             xstb_o;
  logic             xsigned_o;
  logic [1:0]       xsiz_o;
  logic             xack_i;
  logic [DW-1:0]    xdat_i;

  logic [NM-1:0]    grant_o;

  modport master (
    input  m_dat_i, m_adr_i, m_we_i, m_cyc_i, m_stb_i, m_signed_i, m_siz_i,
    input  xack_i, xdat_i,
    output m_ack_o, m_err_o, m_dat_o,
    output xdat_o, xadr_o, xwe_o, xcyc_o, xstb_o, xsigned_o, xsiz_o,
    output grant_o
  );

  modport slave (
    output m_dat_i, m_adr_i, m_we_i, m_cyc_i, m_stb_i, m_signed_i, m_siz_i,
    output xack_i, xdat_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  xdat_o, xadr_o, xwe_o, xcyc_o, xstb_o, xsigned_o, xsiz_o,
    input  grant_o
  );

endinterface

// File: rtl/kcp_rr_pick.sv
// Rotating-priority search: first set request at or after i_ptr, wrapping
// to index 0. Purely combinational.
module kcp_rr_pick #(
  parameter int unsigned NM = 2,
  parameter int unsigned PW = 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_valid,
  output logic [PW-1:0] o_idx
);

  logic          w_hi_valid;
  logic [PW-1:0] w_hi_idx;
  logic          w_lo_valid;
  logic [PW-1:0] w_lo_idx;

  // Scan downwards so the lowest qualifying index is the last one written.
  // The upper half (>= ptr) beats the wrapped lower half.
  always_comb begin
    w_hi_valid = 1'b0;
    w_hi_idx   = '0;
    w_lo_valid = 1'b0;
    w_lo_idx   = '0;
    for (int i = int'(NM) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_valid = 1'b1;
        w_lo_idx   = PW'(i);
        if (PW'(i) >= i_ptr) begin
          w_hi_valid = 1'b1;
          w_hi_idx   = PW'(i);
        end
      end
    end
  end

  assign o_valid = w_hi_valid | w_lo_valid;
  assign o_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin arbiter onto one X-port, holding the grant for the
// owner's whole cyc, with an optional stalled-strobe watchdog.
module bus_arbiter_rr
  import kcp_bus_pkg::*;
#(
  parameter int unsigned NM      = 2,
  parameter int unsigned DW      = 64,
  parameter int unsigned AW      = 64,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TW      = 16
) (
  input logic               clk_i,
  input logic               reset_i,
  bus_arbiter_rr_if.master  io_bus
);

  localparam int unsigned PW = clog2_min1(NM);

  arb_state_e    r_state;
  arb_state_e    w_state_d;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_d;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] w_owner_d;
  logic [TW-1:0] r_wdog;
  logic [TW-1:0] w_wdog_d;

  logic          w_pick_valid;
  logic [PW-1:0] w_pick_idx;
  logic          w_owned;
  logic          w_active;
  logic          w_stall;
  logic          w_err_hit;

  logic [DW-1:0] w_dat_arr [NM];
  logic [AW-1:0] w_adr_arr [NM];
  logic [1:0]    w_siz_arr [NM];

  kcp_rr_pick #(
    .NM (NM),
    .PW (PW)
  ) u_pick (
    .i_req   (io_bus.m_cyc_i),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    for (int k = 0; k < int'(NM); k++) begin
      w_dat_arr[k] = io_bus.m_dat_i[k*DW +: DW];
      w_adr_arr[k] = io_bus.m_adr_i[k*AW +: AW];
      w_siz_arr[k] = io_bus.m_siz_i[k*2 +: 2];
    end
  end

  // Output gating by reset is combinational so the reset cycle itself is quiet.
  assign w_owned  = (r_state == StOwned) && !reset_i;
  assign w_active = w_owned && io_bus.m_cyc_i[r_owner];
  assign w_stall  = w_active && io_bus.m_stb_i[r_owner] && !io_bus.xack_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_owner <= w_owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_owner_d = r_owner;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_owner_d = w_pick_idx;
          w_state_d = StOwned;
        end
      end
      StOwned: begin
        if (!io_bus.m_cyc_i[r_owner]) begin
          w_state_d = StIdle;
          w_ptr_d   = (r_owner == PW'(NM - 1)) ? '0 : r_owner + PW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Watchdog: error lands on the TIMEOUT-th consecutive stalled strobe.
  assign w_err_hit = (TIMEOUT != 0) && w_stall && (r_wdog == TW'(TIMEOUT - 1));

  always_comb begin
    w_wdog_d = '0;
    if ((TIMEOUT != 0) && w_stall && !w_err_hit) begin
      w_wdog_d = r_wdog + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= w_wdog_d;
    end
  end

  // Outputs
  always_comb begin
    io_bus.xdat_o    = '0;
    io_bus.xadr_o    = '0;
    io_bus.xwe_o     = 1'b0;
    io_bus.xcyc_o    = 1'b0;
    io_bus.xstb_o    = 1'b0;
    io_bus.xsigned_o = 1'b0;
    io_bus.xsiz_o    = '0;
    io_bus.m_ack_o   = '0;
    io_bus.m_err_o   = '0;
    io_bus.m_dat_o   = '0;
    io_bus.grant_o   = '0;
    if (w_active) begin
      io_bus.xdat_o    = w_dat_arr[r_owner];
      io_bus.xadr_o    = w_adr_arr[r_owner];
      io_bus.xwe_o     = io_bus.m_we_i[r_owner];
      io_bus.xcyc_o    = 1'b1;
      io_bus.xstb_o    = io_bus.m_stb_i[r_owner];
      io_bus.xsigned_o = io_bus.m_signed_i[r_owner];
      io_bus.xsiz_o    = w_siz_arr[r_owner];
    end
    for (int k = 0; k < int'(NM); k++) begin
      if (w_owned && (PW'(k) == r_owner)) begin
        io_bus.grant_o[k]            = 1'b1;
        io_bus.m_ack_o[k]            = io_bus.xack_i;
        io_bus.m_err_o[k]            = w_err_hit;
        io_bus.m_dat_o[k*DW +: DW]   = io_bus.xdat_i;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench: a 2-master arbiter with a 5-cycle watchdog and a 3-master
// arbiter with the watchdog disabled, each driven through its own interface.
module tb_bus_arbiter_rr;
  import kcp_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  bus_arbiter_rr_if #(.NM(2), .DW(16), .AW(16)) bus_a ();
  bus_arbiter_rr_if #(.NM(3), .DW(16), .AW(16)) bus_b ();

  bus_arbiter_rr #(
    .NM(2), .DW(16), .AW(16), .TIMEOUT(5), .TW(4)
  ) u_dut_a (
    .clk_i   (clk),
    .reset_i (rst_a),
    .io_bus  (bus_a)
  );

  bus_arbiter_rr #(
    .NM(3), .DW(16), .AW(16), .TIMEOUT(0), .TW(4)
  ) u_dut_b (
    .clk_i   (clk),
    .reset_i (rst_b),
    .io_bus  (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    bus_a.m_dat_i = '0; bus_a.m_adr_i = '0; bus_a.m_we_i = '0; bus_a.m_cyc_i = '0;
    bus_a.m_stb_i = '0; bus_a.m_signed_i = '0; bus_a.m_siz_i = '0;
    bus_a.xack_i = 1'b0; bus_a.xdat_i = '0;
  endtask

  task automatic clr_b();
    bus_b.m_dat_i = '0; bus_b.m_adr_i = '0; bus_b.m_we_i = '0; bus_b.m_cyc_i = '0;
    bus_b.m_stb_i = '0; bus_b.m_signed_i = '0; bus_b.m_siz_i = '0;
    bus_b.xack_i = 1'b0; bus_b.xdat_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int       order [4];
    logic [2:0] oh;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;

    rst_a = 1'b1;
    rst_b = 1'b1;
    clr_a();
    clr_b();
    tick();
    tick();

    // Reset gating holds even with a request and an ack present
    bus_a.m_cyc_i = 2'b01; bus_a.m_stb_i = 2'b01;
    bus_a.xack_i = 1'b1; bus_a.xdat_i = 16'hFFFF;
    #1;
    chk("rst_grant", bus_a.grant_o, 2'b00);
    chk("rst_xcyc", bus_a.xcyc_o, 1'b0);
    chk("rst_ack", bus_a.m_ack_o, 2'b00);
    chk("rst_mdat", bus_a.m_dat_o, 32'h0);
    chk("rst_b_grant", bus_b.grant_o, 3'b000);
    tick();
    #1;
    chk("rst_hold_grant", bus_a.grant_o, 2'b00);
    tick();
    clr_a();
    rst_a = 1'b0;

    // Single request from master 1
    tick();
    bus_a.m_cyc_i = 2'b10; bus_a.m_stb_i = 2'b10; bus_a.m_we_i = 2'b10;
    bus_a.m_signed_i = 2'b10;
    bus_a.m_adr_i = {16'h1234, 16'hAAAA};
    bus_a.m_dat_i = {16'hBEEF, 16'h1111};
    bus_a.m_siz_i = {SIZ_WORD, SIZ_BYTE};
    #1;
    chk("t1_c0_grant", bus_a.grant_o, 2'b00);
    tick();
    #1;
    chk("t1_c1_grant", bus_a.grant_o, 2'b10);
    chk("t1_xadr", bus_a.xadr_o, 16'h1234);
    chk("t1_xdat", bus_a.xdat_o, 16'hBEEF);
    chk("t1_xwe", bus_a.xwe_o, 1'b1);
    chk("t1_xstb", bus_a.xstb_o, 1'b1);
    chk("t1_xsigned", bus_a.xsigned_o, 1'b1);
    chk("t1_xsiz", bus_a.xsiz_o, SIZ_WORD);
    chk("t1_c1_ack", bus_a.m_ack_o, 2'b00);
    tick();
    #1;
    chk("t1_c2_ack", bus_a.m_ack_o, 2'b00);
    tick();
    bus_a.xack_i = 1'b1; bus_a.xdat_i = 16'h5A5A;
    #1;
    chk("t1_c3_ack", bus_a.m_ack_o, 2'b10);
    chk("t1_c3_mdat", bus_a.m_dat_o, {16'h5A5A, 16'h0000});
    chk("t1_c3_err", bus_a.m_err_o, 2'b00);
    tick();
    bus_a.xack_i = 1'b0; bus_a.m_cyc_i = 2'b00; bus_a.m_stb_i = 2'b00;
    #1;
    chk("t1_c4_ack", bus_a.m_ack_o, 2'b00);
    chk("t1_c4_grant", bus_a.grant_o, 2'b10);
    chk("t1_c4_xcyc", bus_a.xcyc_o, 1'b0);
    tick();
    #1;
    chk("t1_idle_grant", bus_a.grant_o, 2'b00);

    // Bus lock: master 0 keeps cyc across 4 acks while master 1 waits
    tick();
    bus_a.m_cyc_i = 2'b11; bus_a.m_stb_i = 2'b11;
    bus_a.m_adr_i = {16'h1234, 16'h0A0A};
    #1;
    chk("t3_idle_grant", bus_a.grant_o, 2'b00);
    tick();
    #1;
    chk("t3_grant0", bus_a.grant_o, 2'b01);
    chk("t3_xadr", bus_a.xadr_o, 16'h0A0A);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_a.xack_i = 1'b1;
      #1;
      chk("t3_lock_ack", bus_a.m_ack_o, 2'b01);
      chk("t3_lock_grant", bus_a.grant_o, 2'b01);
    end
    tick();
    bus_a.xack_i = 1'b0; bus_a.m_cyc_i = 2'b10; bus_a.m_stb_i = 2'b10;
    #1;
    chk("t3_rel_grant", bus_a.grant_o, 2'b01);
    chk("t3_rel_xcyc", bus_a.xcyc_o, 1'b0);
    tick();
    #1;
    chk("t3_gap_grant", bus_a.grant_o, 2'b00);
    tick();
    #1;
    chk("t3_grant1", bus_a.grant_o, 2'b10);

    // Watchdog: first stalled cycle is this one
    chk("wd_s1_err", bus_a.m_err_o, 2'b00);
    for (int k = 2; k <= 5; k++) begin
      tick();
      #1;
      chk("wd_stall_err", bus_a.m_err_o, (k == 5) ? 2'b10 : 2'b00);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("wd_restart_err", bus_a.m_err_o, 2'b00);
    end
    tick();
    bus_a.xack_i = 1'b1;
    #1;
    chk("wd_ack5_ack", bus_a.m_ack_o, 2'b10);
    chk("wd_ack5_err", bus_a.m_err_o, 2'b00);
    tick();
    bus_a.xack_i = 1'b0;
    #1;
    chk("wd_after_ack_err", bus_a.m_err_o, 2'b00);
    tick();
    clr_a();
    tick();

    // 3-master rotation with every master requesting continuously
    rst_b = 1'b0;
    tick();
    bus_b.m_cyc_i = 3'b111; bus_b.m_stb_i = 3'b111;
    #1;
    chk("t2_idle_grant", bus_b.grant_o, 3'b000);
    for (int j = 0; j < 4; j++) begin
      oh = 3'b001 << order[j];
      tick();
      bus_b.xack_i = 1'b1;
      #1;
      chk("t2_grant", bus_b.grant_o, oh);
      chk("t2_ack", bus_b.m_ack_o, oh);
      chk("t2_xcyc", bus_b.xcyc_o, 1'b1);
      tick();
      bus_b.xack_i = 1'b0;
      bus_b.m_cyc_i = 3'b111 & ~oh; bus_b.m_stb_i = 3'b111 & ~oh;
      #1;
      chk("t2_rel_grant", bus_b.grant_o, oh);
      chk("t2_rel_xcyc", bus_b.xcyc_o, 1'b0);
      tick();
      if (j < 3) begin
        bus_b.m_cyc_i = 3'b111; bus_b.m_stb_i = 3'b111;
      end else begin
        bus_b.m_cyc_i = 3'b100; bus_b.m_stb_i = 3'b100;
      end
      #1;
      chk("t2_gap_grant", bus_b.grant_o, 3'b000);
      chk("t2_gap_xcyc", bus_b.xcyc_o, 1'b0);
    end

    // Reset in the middle of a master-2 transfer
    tick();
    #1;
    chk("t5_grant2", bus_b.grant_o, 3'b100);
    chk("t5_xcyc", bus_b.xcyc_o, 1'b1);
    rst_b = 1'b1;
    bus_b.xack_i = 1'b1;
    #1;
    chk("t5_rst_grant", bus_b.grant_o, 3'b000);
    chk("t5_rst_xcyc", bus_b.xcyc_o, 1'b0);
    chk("t5_rst_xstb", bus_b.xstb_o, 1'b0);
    chk("t5_rst_ack", bus_b.m_ack_o, 3'b000);
    tick();
    rst_b = 1'b0;
    bus_b.xack_i = 1'b0;
    #1;
    chk("t5_idle_grant", bus_b.grant_o, 3'b000);
    tick();
    #1;
    chk("t5_regrant", bus_b.grant_o, 3'b100);

    // Owner 2 releases, pointer wraps, masters 0 and 1 contend
    tick();
    bus_b.m_cyc_i = 3'b011; bus_b.m_stb_i = 3'b011;
    #1;
    chk("t6_rel_grant", bus_b.grant_o, 3'b100);
    chk("t6_rel_xcyc", bus_b.xcyc_o, 1'b0);
    tick();
    #1;
    chk("t6_gap_grant", bus_b.grant_o, 3'b000);
    tick();
    #1;
    chk("t6_wrap_grant", bus_b.grant_o, 3'b001);
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      chk("t6_nowdog_err", bus_b.m_err_o, 3'b000);
    end
    chk("t6_hold_grant", bus_b.grant_o, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
